// File: rtl/decrypt_scheduler_if.sv
// Request/response handshake bundle between the two frame sources, the
// decrypt scheduler and the plaintext consumer.
interface decrypt_scheduler_if #(
    parameter int DATA_W = 78,
    parameter int OUT_W  = 60
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [OUT_W-1:0]  resp_data;
    logic              resp_chan;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, resp_ready,
        output req0_ready, req1_ready, resp_valid, resp_data, resp_chan
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, resp_ready,
        input  req0_ready, req1_ready, resp_valid, resp_data, resp_chan
    );
endinterface

// File: rtl/decrypt_scheduler.sv
// Round-robin sharing of one Decrypter between two channels, one frame in
// flight; returns the captured plaintext tagged with the issuing channel.
//
// state   | meaning
// IDLE    | no frame in flight, arbitrating between req0/req1
// WAIT    | frame held on dec_data, counting down the Decrypter latency
// RESP    | plaintext held on the response port until resp_ready
module decrypt_scheduler #(
    parameter int DATA_W  = 78,
    parameter int OUT_W   = 60,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    decrypt_scheduler_if.slave   bus,
    output logic [DATA_W-1:0]    dec_data,
    input  logic [OUT_W-1:0]     dec_result,
    output logic                 busy,
    output logic [CNT_W-1:0]     done_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   dec_data_q, dec_data_d;
    logic [OUT_W-1:0]    resp_data_q, resp_data_d;
    logic                resp_chan_q, resp_chan_d;
    logic                resp_valid_q, resp_valid_d;
    logic                busy_q, busy_d;
    logic                last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    done_count_q, done_count_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;

    logic grant0, grant1, accept0, accept1;

    // On contention the channel that did not win last time gets the grant.
    always_comb begin
        grant1  = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
        grant0  = bus.req0_valid & ~grant1;
        accept0 = (state_q == ST_IDLE) & grant0;
        accept1 = (state_q == ST_IDLE) & grant1;
    end

    always_comb begin
        state_d      = state_q;
        dec_data_d   = dec_data_q;
        resp_data_d  = resp_data_q;
        resp_chan_d  = resp_chan_q;
        resp_valid_d = resp_valid_q;
        last_grant_d = last_grant_q;
        done_count_d = done_count_q;
        wait_cnt_d   = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept0 | accept1) begin
                    dec_data_d   = accept1 ? bus.req1_data : bus.req0_data;
                    resp_chan_d  = accept1;
                    last_grant_d = accept1;
                    wait_cnt_d   = WAIT_LOAD;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Counter runs down to zero first, so capture lands LATENCY+1
                // edges after accept, one edge after the result has settled.
                if (wait_cnt_q == 4'd0) begin
                    resp_data_d  = dec_result;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    done_count_d = done_count_q + CNT_W'(1);
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= ST_IDLE;
            dec_data_q   <= '0;
            resp_data_q  <= '0;
            resp_chan_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            last_grant_q <= 1'b1;
            done_count_q <= '0;
            wait_cnt_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            dec_data_q   <= dec_data_d;
            resp_data_q  <= resp_data_d;
            resp_chan_q  <= resp_chan_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            done_count_q <= done_count_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign bus.req0_ready = accept0;
    assign bus.req1_ready = accept1;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_chan  = resp_chan_q;
    assign dec_data       = dec_data_q;
    assign busy           = busy_q;
    assign done_count     = done_count_q;

endmodule
